pdm_decimator: RTL and testbench

- PDM microphone receiver: the receive counterpart of the buzzer's sigma-delta 1-bit output path.
- Generates the microphone bit clock and samples the 1-bit pulse-density stream.
- Decimates the stream through a 2nd-order CIC filter into 16-bit unsigned samples at about 15.6 kHz.
- Each sample is presented with a one-cycle start strobe, the same sound/start convention the sound pipeline already uses.

---
 rtl/audio_pkg.sv | 18 +
 rtl/pdm_cic2.sv | 54 +++++
 rtl/pdm_decimator.sv | 151 +++++++++++++++
 tb/tb_pdm_decimator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and sizing helpers for the PDM receive path.
// Stereo capture is built when PDM_STEREO_EN is defined.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int CIC_ORDER = 2;
  localparam int SOUND_W   = 16;

  function automatic int cic_width(input int decim);
    return 1 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_cic2.sv
// One mono 2nd-order CIC decimator channel, differential delay 1.
// Modular W-bit arithmetic; wrap-around in the integrators is intended.
module pdm_cic2
  import audio_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         int_en_i,
  input  logic         dec_en_i,
  input  logic         bit_i,
  output logic [W-1:0] res_o
);

  logic [W-1:0] i1_q, i2_q;
  logic [W-1:0] d1_q, d2_q;
  logic [W-1:0] r_q;
  logic [W-1:0] i1_d, c1, c2;

  assign i1_d = i1_q + W'(bit_i);
  assign c1   = i2_q - d1_q;
  assign c2   = c1 - d2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_q <= '0;
      i2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      r_q  <= '0;
    end else if (clr_i) begin
      i1_q <= '0;
      i2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      r_q  <= '0;
    end else begin
      if (int_en_i) begin
        i1_q <= i1_d;
        i2_q <= i2_q + i1_d;
      end
      if (dec_en_i) begin
        d1_q <= i2_q;
        d2_q <= c1;
        r_q  <= c2;
      end
    end
  end

  assign res_o = r_q;

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone receiver: bit clock, synchronizer, CIC decimation.
// Define PDM_STEREO_EN to add the right channel (sound_r).
module pdm_decimator
  import audio_pkg::*;
#(
  parameter int HALF_DIV = 25,
  parameter int DECIM    = 64,
  parameter int SETTLE_N = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pdm_in,
  output logic               pdm_clk,
  output logic [SOUND_W-1:0] sound,
`ifdef PDM_STEREO_EN
  output logic [SOUND_W-1:0] sound_r,
`endif
  output logic               start,
  output logic               active
);

  localparam int W   = cic_width(DECIM);
  localparam int DW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW  = $clog2(DECIM);
  localparam int SCW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
  localparam int PAD = SOUND_W - (W - 1);

  logic [1:0]         sync_q;
  logic [DW-1:0]      div_q;
  logic               pclk_q;
  state_e             st_q, st_d;
  logic [BW-1:0]      bcnt_q;
  logic               dec_q, vld_q;
  logic [SCW-1:0]     set_q;
  logic [SOUND_W-1:0] sound_q;
  logic               start_q;
  logic               run, clr, wrap;
  logic               rise_tick, win_end, emit;
  logic [W-1:0]       res_l;

  // Saturate to DECIM^2-1, then left-justify with zero fill.
  function automatic logic [SOUND_W-1:0] scale(
    input logic [W-1:0] r
  );
    logic [W-2:0] sat;
    sat = r[W-1] ? '1 : r[W-2:0];
    return SOUND_W'(sat) << PAD;
  endfunction

  assign run       = (st_q != IDLE);
  assign clr       = !enable || !run;
  assign wrap      = run && (div_q == DW'(HALF_DIV - 1));
  assign rise_tick = wrap && !pclk_q;
  assign win_end   = rise_tick && (bcnt_q == BW'(DECIM - 1));
  assign emit      = enable && vld_q && (st_q == RUN);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:
        if (enable)
          st_d = (SETTLE_N == 0) ? RUN : SETTLE;
      SETTLE:
        if (vld_q && int'(set_q) == SETTLE_N - 1)
          st_d = RUN;
      default: ;
    endcase
    if (!enable) st_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      st_q    <= IDLE;
      bcnt_q  <= '0;
      dec_q   <= 1'b0;
      vld_q   <= 1'b0;
      set_q   <= '0;
      sound_q <= '0;
      start_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pdm_in};
      st_q    <= st_d;
      start_q <= 1'b0;
      if (clr) begin
        div_q  <= '0;
        pclk_q <= 1'b0;
        bcnt_q <= '0;
        dec_q  <= 1'b0;
        vld_q  <= 1'b0;
        set_q  <= '0;
      end else begin
        div_q <= wrap ? '0 : div_q + DW'(1);
        if (wrap) pclk_q <= !pclk_q;
        if (rise_tick) bcnt_q <= bcnt_q + BW'(1);
        // Combs run one clk after the last integrate of a window.
        dec_q <= win_end;
        vld_q <= dec_q;
        if (vld_q && st_q == SETTLE) set_q <= set_q + SCW'(1);
        if (emit) begin
          sound_q <= scale(res_l);
          start_q <= 1'b1;
        end
      end
    end
  end

  pdm_cic2 #(.W(W)) u_cic_l (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .int_en_i (rise_tick),
    .dec_en_i (dec_q),
    .bit_i    (sync_q[1]),
    .res_o    (res_l)
  );

`ifdef PDM_STEREO_EN
  logic               fall_tick;
  logic [W-1:0]       res_r;
  logic [SOUND_W-1:0] sound_r_q;

  assign fall_tick = wrap && pclk_q;

  pdm_cic2 #(.W(W)) u_cic_r (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .int_en_i (fall_tick),
    .dec_en_i (dec_q),
    .bit_i    (sync_q[1]),
    .res_o    (res_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sound_r_q <= '0;
    else if (emit) sound_r_q <= scale(res_r);
  end

  assign sound_r = sound_r_q;
`endif

  assign pdm_clk = pclk_q;
  assign sound   = sound_q;
  assign start   = start_q;
  assign active  = (st_q == RUN);

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator against a cumulative-sum CIC model.
`timescale 1ns/1ps
module tb_pdm_decimator;

  localparam int HALF_DIV = 10;
  localparam int DECIM    = 64;
  localparam int SETTLE_N = 2;
  localparam int CLK_P    = 10;
  localparam int SPACING  = 2 * HALF_DIV * DECIM;
  localparam int BUDGET1  = SPACING + 200;

  typedef struct {
    logic [15:0] s;
    longint      t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pdm_in = 1'b0;
  logic        pdm_clk, start, active;
  logic [15:0] sound;
`ifdef PDM_STEREO_EN
  logic [15:0] sound_r;
`endif

  int     checks = 0;
  int     errors = 0;
  int     mode = 0;
  int     epoch = 0;
  int     nbits = 0;
  int     nstrobe = 0;
  longint cyc = 0;
  exp_t   expq[$];

  pdm_decimator #(
    .HALF_DIV (HALF_DIV),
    .DECIM    (DECIM),
    .SETTLE_N (SETTLE_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .pdm_in  (pdm_in),
    .pdm_clk (pdm_clk),
    .sound   (sound),
`ifdef PDM_STEREO_EN
    .sound_r (sound_r),
`endif
    .start   (start),
    .active  (active)
  );

  always #(CLK_P / 2) clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string nm,
                              input longint act,
                              input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] to_sound(input longint r);
    longint m;
    m = (r > DECIM * DECIM - 1) ? DECIM * DECIM - 1 : r;
    return 16'(m * (65536 / (DECIM * DECIM)));
  endfunction

  // Data source: new bit each falling pdm_clk, stable at the rise.
  initial forever begin
    @(negedge pdm_clk);
    case (mode)
      1:       pdm_in = 1'b1;
      2:       pdm_in = ~pdm_in;
      3:       pdm_in = 1'($urandom & 1);
      default: pdm_in = 1'b0;
    endcase
  end

  // Reference: r = second difference of double cumulative sums.
  initial begin
    longint s1, s2, p1, p2, r;
    int     win, my_ep;
    exp_t   e;
    s1 = 0; s2 = 0; p1 = 0; p2 = 0; win = 0; my_ep = 0;
    forever begin
      @(posedge pdm_clk);
      if (my_ep != epoch) begin
        s1 = 0; s2 = 0; p1 = 0; p2 = 0;
        win = 0; nbits = 0; my_ep = epoch;
      end
      nbits++;
      s1 += longint'(pdm_in);
      s2 += s1;
      if (nbits % DECIM == 0) begin
        win++;
        r  = s2 - 2 * p1 + p2;
        p2 = p1;
        p1 = s2;
        if (win > SETTLE_N) begin
          e.s = to_sound(r);
          e.t = $time + 2 * CLK_P + CLK_P / 2;
          expq.push_back(e);
        end
      end
    end
  end

  initial begin
    longint last;
    int     last_ep;
    bit     have;
    exp_t   e;
    have = 0; last = 0; last_ep = 0;
    forever begin
      @(negedge clk);
      if (start) begin
        nstrobe++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start sound=%h t=%0t",
                   sound, $time);
        end else begin
          e = expq.pop_front();
          chk("sound", longint'(sound), longint'(e.s));
          chk("strobe_time", $time, e.t);
        end
        chk("active_on_start", longint'(active), 1);
        if (have && last_ep == epoch)
          chk("spacing", cyc - last, SPACING);
        have = 1; last = cyc; last_ep = epoch;
      end
    end
  end

  task automatic wait_strobes(input int n);
    int tgt, c;
    tgt = nstrobe + n;
    c = 0;
    while (nstrobe < tgt && c < (SETTLE_N + n + 2) * BUDGET1) begin
      @(negedge clk);
      c++;
    end
    #1;
    chk("strobe_count", longint'(nstrobe >= tgt), 1);
  endtask

  task automatic wait_bit(input int k);
    int c;
    c = 0;
    while ((nbits % DECIM) != k && c < 2 * BUDGET1) begin
      @(negedge clk);
      c++;
    end
    chk("reach_bit", longint'(nbits % DECIM), k);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pdm_clk", longint'(pdm_clk), 0);
    chk("rst_sound", longint'(sound), 0);
    chk("rst_start", longint'(start), 0);
    chk("rst_active", longint'(active), 0);

    // Reset release and enable in the same cycle.
    mode = 1; pdm_in = 1'b1;
    #2; rst = 1'b1; enable = 1'b1;
    @(negedge clk);
    chk("idle_after_release", longint'(active), 0);
    wait_strobes(4);

    mode = 2;
    wait_strobes(4);

    mode = 0;
    wait_strobes(3);

    // Abandon a window part-way through.
    wait_bit(30);
    @(negedge clk);
    enable = 1'b0;
    epoch++;
    @(negedge clk);
    chk("dis_pdm_clk", longint'(pdm_clk), 0);
    chk("dis_active", longint'(active), 0);
    repeat (40) @(negedge clk);
    chk("dis_no_pending", longint'(expq.size()), 0);
    mode = 3;
    enable = 1'b1;
    wait_strobes(3);

    // Asynchronous reset pulse mid-window.
    wait_bit(20);
    @(posedge clk);
    #3 rst = 1'b0;
    epoch++;
    #1;
    chk("arst_pdm_clk", longint'(pdm_clk), 0);
    chk("arst_sound", longint'(sound), 0);
    chk("arst_start", longint'(start), 0);
    chk("arst_active", longint'(active), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    wait_strobes(3);

    chk("queue_drained", longint'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
